// File: rtl/sram_like_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter_if
// One SRAM-like request/response port.
//   req/wr/size/wstrb/addr/wdata : request beat, driven by the issuing side
//   addr_ok                      : request beat accepted this cycle
//   data_ok/rdata                : in-order response valid and read data
// modport master : the side that issues requests (CPU requester, or the
//                  arbiter toward the memory bridge)
// modport slave  : the side that accepts requests
// ---------------------------------------------------------------------------
interface sram_like_arbiter_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/sram_like_arbiter.sv
// ---------------------------------------------------------------------------
// sram_like_arbiter
// Shares one SRAM-like memory port between the fetch (inst_sram) and
// memory-stage (data_sram) requesters. Accepted transactions are recorded
// in an ID FIFO (0 = inst, 1 = data) so in-order responses are steered back
// to the requester that issued them.
//
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   inst_sram  : slave side, fetch requester
//   data_sram  : slave side, data requester
//   mem        : master side, shared port toward the bus bridge
//
// Parameters:
//   OUTSTANDING : ID FIFO depth (power of 2, >= 2)
//   PTR_W       : log2(OUTSTANDING)
//
// Optional build macro ARB_RR_EN: round-robin between the two requesters
// when both request and no lock is held. Without it, data has fixed
// priority over inst.
// ---------------------------------------------------------------------------
module sram_like_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int PTR_W       = $clog2(OUTSTANDING)
) (
    input  logic                  clk,
    input  logic                  reset,
    sram_like_arbiter_if.slave    inst_sram,
    sram_like_arbiter_if.slave    data_sram,
    sram_like_arbiter_if.master   mem
);

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(OUTSTANDING);

    // ID FIFO state
    logic [OUTSTANDING-1:0] fifo_q, fifo_d;
    logic [PTR_W-1:0]       wptr_q, wptr_d;
    logic [PTR_W-1:0]       rptr_q, rptr_d;
    logic [PTR_W:0]         count_q, count_d;

    // Lock keeps the presented request stable until the bridge accepts it
    logic lock_valid_q, lock_valid_d;
    logic lock_id_q, lock_id_d;

`ifdef ARB_RR_EN
    logic rr_last_q, rr_last_d;
`endif

    logic fifo_full;
    logic fifo_empty;
    logic grant;
    logic mem_req;
    logic sel_data;
    logic push;
    logic pop;
    logic head_id;

    assign fifo_full  = (count_q == CNT_FULL);
    assign fifo_empty = (count_q == '0);

    // Grant selection
    always_comb begin
        grant = ID_INST;
        if (lock_valid_q) begin
            grant = lock_id_q;
        end else begin
`ifdef ARB_RR_EN
            if (inst_sram.req && data_sram.req)
                grant = ~rr_last_q;
            else
                grant = data_sram.req ? ID_DATA : ID_INST;
`else
            grant = data_sram.req ? ID_DATA : ID_INST;
`endif
        end
    end

    assign mem_req  = !reset && !fifo_full &&
                      (lock_valid_q || inst_sram.req || data_sram.req);
    // Fields default to inst whenever nothing is presented
    assign sel_data = mem_req && (grant == ID_DATA);

    assign mem.req   = mem_req;
    assign mem.wr    = sel_data ? data_sram.wr    : inst_sram.wr;
    assign mem.size  = sel_data ? data_sram.size  : inst_sram.size;
    assign mem.wstrb = sel_data ? data_sram.wstrb : inst_sram.wstrb;
    assign mem.addr  = sel_data ? data_sram.addr  : inst_sram.addr;
    assign mem.wdata = sel_data ? data_sram.wdata : inst_sram.wdata;

    assign push = mem_req && mem.addr_ok;
    // data_ok with nothing outstanding is a protocol error and is dropped
    assign pop  = !reset && mem.data_ok && !fifo_empty;

    assign inst_sram.addr_ok = push && (grant == ID_INST);
    assign data_sram.addr_ok = push && (grant == ID_DATA);

    assign head_id = fifo_q[rptr_q];

    assign inst_sram.data_ok = pop && (head_id == ID_INST);
    assign data_sram.data_ok = pop && (head_id == ID_DATA);
    assign inst_sram.rdata   = mem.rdata;
    assign data_sram.rdata   = mem.rdata;

    // Next-state
    always_comb begin
        fifo_d       = fifo_q;
        wptr_d       = wptr_q;
        rptr_d       = rptr_q;
        count_d      = count_q;
        lock_valid_d = lock_valid_q;
        lock_id_d    = lock_id_q;

        if (push) begin
            fifo_d[wptr_q] = grant;
            wptr_d         = wptr_q + PTR_W'(1);
        end
        if (pop)
            rptr_d = rptr_q + PTR_W'(1);

        if (push && !pop)
            count_d = count_q + (PTR_W+1)'(1);
        else if (pop && !push)
            count_d = count_q - (PTR_W+1)'(1);

        // Lock follows the presented request: held until addr_ok.
        // When mem_req is low (full) the lock is left as is.
        if (mem_req) begin
            lock_valid_d = !mem.addr_ok;
            lock_id_d    = grant;
        end
    end

`ifdef ARB_RR_EN
    always_comb begin
        rr_last_d = rr_last_q;
        if (push)
            rr_last_d = grant;
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_q       <= '0;
            wptr_q       <= '0;
            rptr_q       <= '0;
            count_q      <= '0;
            lock_valid_q <= 1'b0;
            lock_id_q    <= ID_INST;
        end else begin
            fifo_q       <= fifo_d;
            wptr_q       <= wptr_d;
            rptr_q       <= rptr_d;
            count_q      <= count_d;
            lock_valid_q <= lock_valid_d;
            lock_id_q    <= lock_id_d;
        end
    end

`ifdef ARB_RR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            rr_last_q <= ID_INST;
        else
            rr_last_q <= rr_last_d;
    end
`endif

endmodule
